// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the counter family: sequencer states and
// the pass-counter saturation limit.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PASS_MAX = 255;

  // Increment that sticks at PASS_MAX instead of wrapping.
  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == 8'(PASS_MAX)) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/count_sequencer_core.sv
// WIDTH-bit up/down counter with synchronous load and enable.
// Load wins over enable; the count wraps modulo 2^WIDTH.
module updown_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_loadVal,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en) begin
      r_count <= i_dir ? r_count - 1'b1 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven count sequencer: latches a start/term/direction command,
// counts to the terminal value, pulses done, and optionally auto-reloads.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_term,
  input  logic             cmd_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       passes
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_dir;
  logic             r_reload;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_term;
  logic [7:0]       r_passes;

  logic             w_accept;
  logic             w_load;
  logic             w_en;
  logic             w_passInc;
  logic [WIDTH-1:0] w_count;

  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign count     = w_count;
  assign passes    = r_passes;

  // Abort outranks every other exit from LOAD/RUN/DONE and suppresses the
  // counter load and the pass increment in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_passInc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) w_nextState = LOAD;
      end
      LOAD: begin
        if (abort) begin
          w_nextState = IDLE;
        end else begin
          w_load      = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_count == r_term) begin
          w_nextState = DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          w_nextState = IDLE;
        end else begin
          w_passInc = 1'b1;
          if (r_reload) begin
            w_load      = 1'b1;
            w_nextState = RUN;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_dir    <= 1'b0;
      r_reload <= 1'b0;
      r_start  <= '0;
      r_term   <= '0;
      r_passes <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_dir    <= cmd_dir;
        r_reload <= cmd_reload;
        r_start  <= cmd_start;
        r_term   <= cmd_term;
        r_passes <= '0;
      end else if (w_passInc) begin
        r_passes <= satInc(r_passes);
      end
    end
  end

  updown_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_en     (w_en),
    .i_dir    (r_dir),
    .i_loadVal(r_start),
    .o_count  (w_count)
  );

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; every done pulse is matched against
// an expected (count, passes) entry queued by the stimulus side.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_start;
  logic [3:0] cmd_term;
  logic       cmd_reload;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [7:0] passes;

  typedef struct {
    int count;
    int passes;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  count_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_start (cmd_start),
    .cmd_term  (cmd_term),
    .cmd_reload(cmd_reload),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .passes    (passes)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: each done pulse must match the oldest queued expectation.
  // passes is sampled before the DONE-exit increment lands.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedDone: got done=1 count=%0d, expected no pulse", count);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("doneCount", int'(count), e.count);
        checkOutput("donePasses", int'(passes), e.passes);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single handshake edge, then scrambles the
  // command inputs so any late sampling shows up as a wrong count.
  task automatic applyStimulus(input logic dir, input logic [3:0] start,
                               input logic [3:0] term, input logic reload);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_start  = start;
    cmd_term   = term;
    cmd_reload = reload;
    checkOutput("readyBeforeHandshake", int'(cmd_ready), 1);
    nextCycle();
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    cmd_dir    = ~dir;
    cmd_start  = ~start;
    cmd_term   = ~term;
    cmd_reload = ~reload;
    checkOutput("busyInLoad", int'(busy), 1);
  endtask

  // Non-reloading run: walks the count one step per cycle to term, expects
  // one done pulse, then IDLE with passes=1.
  task automatic runSequence(input logic dir, input logic [3:0] start,
                             input logic [3:0] term, input logic abortAtHandshake);
    logic [3:0] expCount;
    int         steps;
    steps    = dir ? int'(4'(start - term)) : int'(4'(term - start));
    expCount = start;
    expQ.push_back('{count: int'(term), passes: 0});
    abort = abortAtHandshake;
    applyStimulus(dir, start, term, 1'b0);
    for (int i = 0; i <= steps; i++) begin
      nextCycle();
      checkOutput("runCount", int'(count), int'(expCount));
      expCount = dir ? expCount - 4'd1 : expCount + 4'd1;
    end
    nextCycle();
    checkOutput("doneHigh", int'(done), 1);
    nextCycle();
    checkOutput("idleReady", int'(cmd_ready), 1);
    checkOutput("idleBusy", int'(busy), 0);
    checkOutput("idleCount", int'(count), int'(term));
    checkOutput("idlePasses", int'(passes), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b1;
    abort      = 1'b1;
    cmd_dir    = 1'b0;
    cmd_start  = 4'd9;
    cmd_term   = 4'd9;
    cmd_reload = 1'b1;
    nextCycle();
    nextCycle();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    checkOutput("resetReady", int'(cmd_ready), 1);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetCount", int'(count), 0);
    checkOutput("resetPasses", int'(passes), 0);
    reset = 1'b0;
    nextCycle();
    checkOutput("idleAfterReset", int'(busy), 0);

    // Up 3->7, down 2->14 across the wrap, start==term, up 14->1 across the wrap.
    runSequence(1'b0, 4'd3, 4'd7, 1'b0);
    runSequence(1'b1, 4'd2, 4'd14, 1'b0);
    runSequence(1'b0, 4'd5, 4'd5, 1'b0);
    runSequence(1'b0, 4'd14, 4'd1, 1'b1);

    // Auto-reload 0->2 with a competing command held on cmd_valid.
    for (int p = 0; p < 4; p++) expQ.push_back('{count: 2, passes: p});
    applyStimulus(1'b0, 4'd0, 4'd2, 1'b1);
    cmd_valid = 1'b1;
    cmd_start = 4'd9;
    cmd_term  = 4'd11;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++) begin
        nextCycle();
        checkOutput("reloadCount", int'(count), i);
        checkOutput("reloadReady", int'(cmd_ready), 0);
        checkOutput("reloadBusy", int'(busy), 1);
      end
      nextCycle();
      checkOutput("reloadDone", int'(done), 1);
      checkOutput("reloadPasses", int'(passes), p);
    end
    nextCycle();
    checkOutput("reloadPassesFour", int'(passes), 4);
    checkOutput("reloadRestart", int'(count), 0);
    cmd_valid = 1'b0;
    abort     = 1'b1;
    nextCycle();
    abort = 1'b0;
    checkOutput("reloadAbortIdle", int'(cmd_ready), 1);
    checkOutput("reloadAbortPasses", int'(passes), 4);

    // Abort at count=4 of a 3->7 run, then abort while idle.
    applyStimulus(1'b0, 4'd3, 4'd7, 1'b0);
    nextCycle();
    checkOutput("abortRunCount3", int'(count), 3);
    nextCycle();
    checkOutput("abortRunCount4", int'(count), 4);
    abort = 1'b1;
    nextCycle();
    abort = 1'b0;
    checkOutput("abortIdle", int'(busy), 0);
    checkOutput("abortCount", int'(count), 4);
    checkOutput("abortPasses", int'(passes), 0);
    abort = 1'b1;
    nextCycle();
    nextCycle();
    abort = 1'b0;
    checkOutput("idleAbortReady", int'(cmd_ready), 1);
    checkOutput("idleAbortCount", int'(count), 4);
    checkOutput("idleAbortPasses", int'(passes), 0);

    // Reset mid-run of a down count 9->3.
    applyStimulus(1'b1, 4'd9, 4'd3, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("preResetCount", int'(count), 8);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("midResetCount", int'(count), 0);
    checkOutput("midResetPasses", int'(passes), 0);
    checkOutput("midResetReady", int'(cmd_ready), 1);
    checkOutput("midResetDone", int'(done), 0);
    nextCycle();
    nextCycle();
    checkOutput("postResetBusy", int'(busy), 0);

    // Saturation: start==term with reload gives a done every two cycles.
    for (int p = 0; p < 260; p++) expQ.push_back('{count: 6, passes: (p > 255) ? 255 : p});
    applyStimulus(1'b0, 4'd6, 4'd6, 1'b1);
    for (int p = 0; p < 260; p++) begin
      nextCycle();
      nextCycle();
    end
    checkOutput("satDone", int'(done), 1);
    abort = 1'b1;
    nextCycle();
    abort = 1'b0;
    checkOutput("satPasses", int'(passes), 255);
    checkOutput("satIdle", int'(cmd_ready), 1);

    nextCycle();
    nextCycle();
    checkOutput("pendingDone", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the count register and of cmd_start/cmd_term.
REQ-002 SHALL have input clk, 1 bit: the clock; all state changes on its rising edge.
REQ-003 SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have input cmd_valid, 1 bit: a requester presents a count command.
REQ-005 SHALL have output cmd_ready, 1 bit: the block accepts a command this cycle.
REQ-006 SHALL have input cmd_dir, 1 bit: 0 = count up, 1 = count down.
REQ-007 SHALL have input cmd_start, WIDTH bits: the initial count value.
REQ-008 SHALL have input cmd_term, WIDTH bits: the terminal count value.
REQ-009 SHALL have input cmd_reload, 1 bit: 1 = auto-reload after each terminal count.
REQ-010 SHALL have input abort, 1 bit: cancels the active sequence.
REQ-011 SHALL have output count, WIDTH bits: the current counter value.
REQ-012 SHALL have output busy, 1 bit: high when the FSM is not in IDLE.
REQ-013 SHALL have output done, 1 bit: a one-cycle terminal-count pulse.
REQ-014 SHALL have output passes, 8 bits: the number of completed terminal counts since the last accepted command.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-016 SHALL drive cmd_ready = (state==IDLE) and busy = (state!=IDLE), both combinational from state.
REQ-017 SHALL, in IDLE with cmd_valid&&cmd_ready at an edge, register dir/start/term/reload, clear passes to 0, and go to LOAD.
REQ-018 SHALL hold cmd fields internally; input changes after the handshake have no effect.
REQ-019 SHALL, in LOAD, set count<=start and go to RUN on the next edge.
REQ-020 SHALL, in RUN, go to DONE if count==term, else set count<=count+1 (dir=0) or count-1 (dir=1) modulo 2^WIDTH.
REQ-021 SHALL require RUN to last exactly ((term-start) mod 2^WIDTH) + 1 cycles for up-counting and ((start-term) mod 2^WIDTH) + 1 cycles for down-counting; the wrap 15->0 / 0->15 is legal.
REQ-022 SHALL assert done iff state==DONE; count holds the term value during DONE.
REQ-023 SHALL, in DONE, increment passes, saturating at 255.
REQ-024 SHALL, in DONE, reload count<=start and go to RUN if reload=1, else go to IDLE.
REQ-025 SHALL, on start==term, pass through RUN for one cycle and then go to DONE.
REQ-026 SHALL, on abort=1 in LOAD/RUN/DONE, go to IDLE on the next edge with count and passes held and passes not incremented; abort takes priority over all other transitions.
REQ-027 SHALL ignore abort in IDLE; abort and a handshake in the same IDLE cycle still accept the command.
REQ-028 SHALL, while in IDLE, hold count at its last value.

Reset
REQ-029 SHALL, on reset=1 at an edge, override abort and handshake and set state=IDLE, count=0, passes=0, and all latched cmd fields=0.
REQ-030 SHALL give outputs the following values after reset: cmd_ready=1, busy=0, done=0.
REQ-031 SHALL, on reset mid-sequence, abandon the sequence with no done pulse.

Structure
REQ-032 SHALL place the state enum (IDLE, LOAD, RUN, DONE) and the PASS_MAX=255 constant in the shared counters package.
REQ-033 SHALL instantiate one sub-module, updown_counter_core (WIDTH-bit synchronous load/enable/dir counter); the FSM drives its load, en, and dir.
REQ-034 SHALL be fully synchronous to clk; no derived or rippled clocks.

Verification
REQ-035 SHALL cover: handshake E0 with up, start=3, term=7, reload=0 -> count 3,4,5,6,7 at E1..E5, done high only in the cycle after E6, IDLE after E7, passes=1.
REQ-036 SHALL cover: down, start=2, term=14 -> count 2,1,0,15,14, a single done pulse, done in the cycle after E6.
REQ-037 SHALL cover: up, start=5, term=5 -> done in the cycle after E2, no count change.
REQ-038 SHALL cover: up, 0->2, reload=1 for 4 terminal counts -> done pulse every 4 cycles, passes=4, busy stays 1, cmd_ready stays 0, and a cmd_valid offered meanwhile is not accepted.
REQ-039 SHALL cover: abort while count=4 in the 3->7 run -> IDLE next edge, count=4, no done, passes=0; an abort in IDLE produces no change.
REQ-040 SHALL cover: reset during RUN -> next cycle count=0, passes=0, cmd_ready=1, no done pulse.
